// File: rtl/wb_stage_regfile.sv
// Writeback stage: MEM/WB capture register, writeback data select, 16 x 32 register file with two async read ports.
// Optional write-before-read bypass on the read ports is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_stage_regfile #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned bitwidth            = 32,
  parameter logic [3:0]  LW_OPCODE           = 4'b0001,
  parameter logic [3:0]  BRANCH_OPCODE       = 4'b0010,
  parameter logic [3:0]  SW_OPCODE           = 4'b0011
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_valid,
  input  logic [3:0]                     mem_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] mem_index,
  input  logic [bitwidth-1:0]            mem_alu_result,
  input  logic [bitwidth-1:0]            mem_rdata,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_a,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_b,
  output logic [bitwidth-1:0]            rd_data_a,
  output logic [bitwidth-1:0]            rd_data_b,
  output logic                           WB_valid,
  output logic [3:0]                     WB_opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
  output logic [bitwidth-1:0]            WB_data,
  output logic                           WB_we,
  output logic [31:0]                    retire_count
);

  localparam int unsigned DEPTH = 2 ** REG_INDEX_BIT_WIDTH;

  logic                           wb_valid_r;
  logic [3:0]                     wb_opcode_r;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_index_r;
  logic [bitwidth-1:0]            wb_data_r;
  logic [31:0]                    retire_count_r;
  logic [bitwidth-1:0]            regfile_r [DEPTH];
  logic                           wb_we_s;
  logic [bitwidth-1:0]            wb_sel_data_s;
  logic [bitwidth-1:0]            rd_data_a_s;
  logic [bitwidth-1:0]            rd_data_b_s;

  // Writeback data select: loads take memory data, everything else the ALU result.
  always_comb begin
    wb_sel_data_s = mem_alu_result;
    if (mem_opcode == LW_OPCODE) begin
      wb_sel_data_s = mem_rdata;
    end else begin
      wb_sel_data_s = mem_alu_result;
    end
  end

  // MEM/WB capture register; a flushed slot is tagged BRANCH so forwarding ignores it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_r  <= 1'b0;
      wb_opcode_r <= 4'b0000;
      wb_index_r  <= '0;
      wb_data_r   <= '0;
    end else if (stall) begin
      wb_valid_r  <= wb_valid_r;
      wb_opcode_r <= wb_opcode_r;
      wb_index_r  <= wb_index_r;
      wb_data_r   <= wb_data_r;
    end else if (flush) begin
      wb_valid_r  <= 1'b0;
      wb_opcode_r <= BRANCH_OPCODE;
      wb_index_r  <= wb_index_r;
      wb_data_r   <= wb_data_r;
    end else begin
      wb_valid_r  <= mem_valid;
      wb_opcode_r <= mem_opcode;
      wb_index_r  <= mem_index;
      wb_data_r   <= wb_sel_data_s;
    end
  end

  // Commit strobe: live slot whose opcode actually writes a register.
  always_comb begin
    wb_we_s = 1'b0;
    case (wb_opcode_r)
      BRANCH_OPCODE: wb_we_s = 1'b0;
      SW_OPCODE:     wb_we_s = 1'b0;
      default:       wb_we_s = wb_valid_r;
    endcase
  end

  // Register file commit; deliberately not gated by stall (a repeated identical write is harmless).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regfile_r[i] <= '0;
      end
    end else if (wb_we_s) begin
      regfile_r[wb_index_r] <= wb_data_r;
    end else begin
      regfile_r[wb_index_r] <= regfile_r[wb_index_r];
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_r <= 32'h0000_0000;
    end else if (wb_valid_r && !stall) begin
      retire_count_r <= retire_count_r + 32'h0000_0001;
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  // Asynchronous read ports, optionally bypassing the in-flight commit.
  always_comb begin
    rd_data_a_s = regfile_r[rd_index_a];
    rd_data_b_s = regfile_r[rd_index_b];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we_s && (rd_index_a == wb_index_r)) begin
      rd_data_a_s = wb_data_r;
    end else begin
      rd_data_a_s = regfile_r[rd_index_a];
    end
    if (wb_we_s && (rd_index_b == wb_index_r)) begin
      rd_data_b_s = wb_data_r;
    end else begin
      rd_data_b_s = regfile_r[rd_index_b];
    end
`else
`endif
  end

  assign rd_data_a    = rd_data_a_s;
  assign rd_data_b    = rd_data_b_s;
  assign WB_valid     = wb_valid_r;
  assign WB_opcode    = wb_opcode_r;
  assign WB_index     = wb_index_r;
  assign WB_data      = wb_data_r;
  assign WB_we        = wb_we_s;
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile: a reference model pushes expected WB state per cycle, popped after each edge.
module tb_wb_stage_regfile;

  localparam logic [3:0] LW  = 4'b0001;
  localparam logic [3:0] BR  = 4'b0010;
  localparam logic [3:0] SW  = 4'b0011;
  localparam logic [3:0] ALU = 4'b0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_opcode = 4'b0000;
  logic [3:0]  mem_index = 4'b0000;
  logic [31:0] mem_alu_result = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  rd_index_a = 4'b0000;
  logic [3:0]  rd_index_b = 4'b0000;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        WB_valid;
  logic [3:0]  WB_opcode;
  logic [3:0]  WB_index;
  logic [31:0] WB_data;
  logic        WB_we;
  logic [31:0] retire_count;

  wb_stage_regfile dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_opcode(mem_opcode),
    .mem_index(mem_index), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .stall(stall), .flush(flush), .rd_index_a(rd_index_a), .rd_index_b(rd_index_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .WB_valid(WB_valid),
    .WB_opcode(WB_opcode), .WB_index(WB_index), .WB_data(WB_data), .WB_we(WB_we),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  idx;
    logic [31:0] data;
    logic        we;
    logic [31:0] retire;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic        m_valid = 1'b0;
  logic [3:0]  m_op = 4'b0000;
  logic [3:0]  m_idx = 4'b0000;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_retire = 32'h0;
  logic [31:0] m_rf [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_we();
    return m_valid && (m_op != BR) && (m_op != SW);
  endfunction

  // Advance the model by one edge with the current inputs, then compare the DUT after that edge.
  task automatic step();
    wb_exp_t e;
    wb_exp_t got;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
      m_retire = 32'h0;
      m_valid = 1'b0; m_op = 4'b0000; m_idx = 4'b0000; m_data = 32'h0;
    end else begin
      if (m_we()) m_rf[m_idx] = m_data;
      if (m_valid && !stall) m_retire = m_retire + 32'h1;
      if (!stall) begin
        if (flush) begin
          m_valid = 1'b0; m_op = BR;
        end else begin
          m_valid = mem_valid; m_op = mem_opcode; m_idx = mem_index;
          m_data = (mem_opcode == LW) ? mem_rdata : mem_alu_result;
        end
      end
    end
    e = '{valid: m_valid, op: m_op, idx: m_idx, data: m_data, we: m_we(), retire: m_retire};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("WB_valid", {31'h0, WB_valid}, {31'h0, got.valid});
    check("WB_opcode", {28'h0, WB_opcode}, {28'h0, got.op});
    check("WB_index", {28'h0, WB_index}, {28'h0, got.idx});
    check("WB_data", WB_data, got.data);
    check("WB_we", {31'h0, WB_we}, {31'h0, got.we});
    check("retire_count", retire_count, got.retire);
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    logic [31:0] v;
    v = m_rf[idx];
`ifdef WB_REGFILE_BYPASS_EN
    if (m_we() && idx == m_idx) v = m_data;
`endif
    return v;
  endfunction

  task automatic check_rd(input logic [3:0] ia, input logic [3:0] ib);
    rd_index_a = ia;
    rd_index_b = ib;
    #1;
    check("rd_data_a", rd_data_a, m_read(ia));
    check("rd_data_b", rd_data_b, m_read(ib));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] idx,
                       input logic [31:0] alu, input logic [31:0] rdat);
    mem_valid = v; mem_opcode = op; mem_index = idx;
    mem_alu_result = alu; mem_rdata = rdat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
    @(posedge clk); #1;
    // 1: reset, then every register reads 0
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) check_rd(4'(i), 4'(15 - i));

    // 2: ALU write to r5
    drive(1'b1, ALU, 4'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd5, 4'd5);

    // 3: load select, then SW / BRANCH to r3 must not write
    drive(1'b1, LW, 4'd3, 32'h0000_0BAD, 32'hCAFE_F00D);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd3, 4'd5);
    drive(1'b1, SW, 4'd3, 32'h1, 32'h0);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd3, 4'd3);
    drive(1'b1, BR, 4'd3, 32'h1, 32'h0);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd3, 4'd3);

    // 4: stall with changing inputs, then flush a valid op to r7
    drive(1'b1, ALU, 4'd2, 32'h0000_0055, 32'h0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 1) ? LW : ALU, 4'(8 + i), $urandom, $urandom);
      step();
    end
    stall = 1'b0;
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd2, 4'd7);
    flush = 1'b1;
    drive(1'b1, ALU, 4'd7, 32'h0000_0777, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    check_rd(4'd7, 4'd7);

    // 5: read r9 in the cycle it is being committed
    drive(1'b1, ALU, 4'd9, 32'hAAAA_5555, 32'h0);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    check_rd(4'd0, 4'd9);
    step();
    check_rd(4'd9, 4'd9);

    // 6: counter wrap, then reset while stalled
    force dut.retire_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_r;
    m_retire = 32'hFFFF_FFFF;
    drive(1'b1, ALU, 4'd4, 32'h0000_0044, 32'h0);
    step();
    drive(1'b1, ALU, 4'd6, 32'h0000_0066, 32'h0);
    step();
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    step();
    step();
    check("retire_wrap", retire_count, 32'h0000_0001);
    drive(1'b1, ALU, 4'd1, 32'h0000_0011, 32'h0);
    step();
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    drive(1'b0, 4'b0000, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) check_rd(4'(i), 4'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Writeback end of the pipeline, and the producer side of the WB forwarding path.
- Captures MEM-stage results into a MEM/WB register and selects the writeback data (ALU result or load data).
- Drives WB_opcode/WB_index/WB_data to the forwarding units and commits the write into a 16 x 32 register file.
- Decode reads the register file through two asynchronous read ports.

Parameters:
REG_INDEX_BIT_WIDTH, 4, register index width; register file depth is 2**REG_INDEX_BIT_WIDTH.
bitwidth, 32, datapath width.
LW_OPCODE, 4'b0001, opcode whose writeback data comes from mem_rdata.
BRANCH_OPCODE, 4'b0010, non-writing opcode.
SW_OPCODE, 4'b0011, non-writing opcode.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
mem_valid  input  1  MEM stage presents a valid instruction.
mem_opcode  input  4  MEM-stage opcode.
mem_index  input  REG_INDEX_BIT_WIDTH  destination register.
mem_alu_result  input  bitwidth  ALU result.
mem_rdata  input  bitwidth  load data from data memory.
stall  input  1  hold MEM/WB register contents.
flush  input  1  squash the instruction being captured.
rd_index_a  input  REG_INDEX_BIT_WIDTH  read port A index.
rd_index_b  input  REG_INDEX_BIT_WIDTH  read port B index.
rd_data_a  output  bitwidth  read port A data.
rd_data_b  output  bitwidth  read port B data.
WB_valid  output  1  MEM/WB register holds a live instruction.
WB_opcode  output  4  registered opcode.
WB_index  output  REG_INDEX_BIT_WIDTH  registered destination.
WB_data  output  bitwidth  registered writeback data.
WB_we  output  1  commit strobe: WB_valid and opcode is neither BRANCH_OPCODE nor SW_OPCODE.
retire_count  output  32  count of instructions retired.

Behaviour:
- Reset (reset high at a clock edge):
  - WB_valid=0, WB_opcode=4'b0000, WB_index=0, WB_data=0, retire_count=0.
  - All register file entries cleared to 0.
  - reset has priority over stall and flush.
- MEM/WB capture, priority reset > stall > flush > load:
  - stall: all WB_* registers hold.
  - flush (no stall): WB_valid<=0 and WB_opcode<=BRANCH_OPCODE, so forwarding units ignore the slot; WB_index and WB_data hold.
  - otherwise: WB_valid<=mem_valid; WB_opcode<=mem_opcode; WB_index<=mem_index; WB_data<=mem_rdata if mem_opcode==LW_OPCODE, else mem_alu_result.
  - Latency: MEM inputs are visible on WB_* one cycle later.
- Commit:
  - WB_we is combinational from the registered WB_valid/WB_opcode.
  - At each rising edge with WB_we=1 and reset=0, regfile[WB_index]<=WB_data.
  - The commit occurs even if stall=1 in that cycle; a repeated commit of identical data during a stall is harmless.
  - Register 0 is an ordinary writable register.
- retire_count: increments by 1 on each edge where WB_valid=1 and stall=0. It wraps 0xFFFFFFFF -> 0.
- Read ports:
  - Asynchronous: rd_data_x = regfile[rd_index_x].
  - Without the optional feature, a read of the register being committed this cycle returns the old value. The WB forwarding units cover this case.
- Both read ports may address the same register; each returns the same value.
- Reset mid-stall: reset wins and clears all state.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: each read port returns WB_data when WB_we=1 and rd_index_x==WB_index (write-before-read). A decode stage built this way needs no WB-stage forwarding unit.
- Undefined: pure array read as above; old value returned during a same-cycle commit.

Test Plan:
1. Reset then idle: assert reset 2 cycles -> all WB_* 0, retire_count 0, rd_data_a for indices 0..15 reads 0.
2. ALU write: mem_valid=1, opcode 4'b0100, index 5, alu 0x12345678, rdata 0xDEADBEEF.
   - Next cycle: WB_data=0x12345678, WB_we=1.
   - Following cycle: rd_index_a=5 -> 0x12345678; retire_count=1.
3. Load select plus non-writers:
   - LW_OPCODE, index 3, rdata 0xCAFEF00D -> reg3=0xCAFEF00D.
   - SW_OPCODE to index 3 with alu 0x1 -> WB_we=0, reg3 unchanged.
   - BRANCH_OPCODE to index 3 with alu 0x1 -> WB_we=0, reg3 unchanged.
4. Stall and flush:
   - Stall 3 cycles with changing MEM inputs -> WB_* constant; retire_count unchanged.
   - flush with a valid ALU op to index 7 -> WB_valid=0, WB_opcode=BRANCH_OPCODE, reg7 unchanged.
5. Same-cycle read of committing register 9 (old 0x0, new 0xAAAA5555):
   - Macro undefined -> rd_data_b=0x0 that cycle, 0xAAAA5555 next.
   - Macro defined -> 0xAAAA5555 immediately.
6. Wrap and reset priority:
   - Force retire_count near 0xFFFFFFFF, retire 2 -> 0x00000001.
   - Assert reset together with stall=1 -> all state cleared.
